arb_mux: RTL and testbench
==========================

Name: arb_mux

Overview:
- Parametrised N_IN-to-1, WIDTH-bit multiplexer with a registered output and valid/ready handshakes on every port.
- Two selection modes: fair round-robin arbitration across requesting inputs, or fixed selection driven by a select input.
- Sits between multiple 16-bit datapath sources (register file read ports, ALU result, immediate, memory data) and a single consumer, such as a bus or writeback stage.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- N_IN, 4, number of input channels. Legal range is N_IN >= 2.
- SEL_W, $clog2(N_IN), width of sel and out_src. Derived from N_IN; not overridden.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- mode, input, 1, selection mode: 0 = round-robin, 1 = fixed select.
- sel, input, SEL_W, channel index used when mode=1.
- in_data, input, N_IN*WIDTH, packed input data. Channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N_IN, per-channel request.
- in_ready, output, N_IN, per-channel accept. One-hot or all zero.
- out_data, output, WIDTH, registered selected data.
- out_valid, output, 1, out_data/out_src hold a valid word.
- out_src, output, SEL_W, index of the channel that produced out_data.
- out_ready, input, 1, consumer accept.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. While rst_n is low, in_ready is all zero. A word held in the output register when reset asserts is discarded.
- Load enable: load = !out_valid | out_ready.
- Grant, mode=0: g is the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N_IN-1, 0, ..., ptr-1 (wrap modulo N_IN). gv = |in_valid.
- Grant, mode=1: g = sel, gv = in_valid[sel]. If sel >= N_IN (non-power-of-2 N_IN), gv=0: nothing is granted and no X is propagated.
- in_ready[i] = load & gv & (i==g). This path is combinational from in_valid, mode, sel, out_valid and out_ready.
- A transfer on input g occurs when in_valid[g] & in_ready[g].
- Rising edge with load & gv:
  - out_data <= channel g data.
  - out_src <= g.
  - out_valid <= 1.
  - If mode=0: ptr <= (g+1) mod N_IN.
  - If mode=1: ptr is unchanged.
- Rising edge with load & !gv: out_valid <= 0. out_data and out_src hold their previous values.
- Rising edge with !load (out_valid & !out_ready): out_data, out_src and out_valid hold. in_ready is all zero, so no input word is lost.
- Latency is 1 cycle from input transfer to out_valid. Sustained throughput is 1 word/cycle when out_ready=1. Simultaneous output drain and input load in the same cycle is required.
- Fairness: in mode 0, a channel that holds in_valid high is granted within N_IN accepted transfers.
- mode and sel are sampled every cycle. A change affects only the next grant; the held output word is not altered.
- Single-requester case: with only channel k valid in mode 0, k is granted every cycle regardless of ptr.
- Handshake rule on the source side: a source must hold in_data stable while in_valid=1 and in_ready=0. The block does not latch unaccepted data.

Test Plan:
- Reset: assert rst_n=0 mid-stream while out_valid=1. Required: out_valid=0, out_data=0, out_src=0, in_ready=0000 immediately. After release, the first mode-0 grant goes to the lowest valid channel.
- Fixed select: mode=1, sel=2, all in_valid=1111, data channels 0-3 = 16'h1111, 2222, 3333, 4444, out_ready=1. Required: in_ready=0100 every cycle, out_data=16'h3333, out_src=2, one cycle after each transfer. Then sel=2 with in_valid[2]=0: in_ready=0000, out_valid drops next cycle.
- Round-robin: mode=0, in_valid=1111 held, out_ready=1. Required: out_src sequence 0,1,2,3,0,1 on consecutive cycles, with matching out_data.
- Pointer wrap and skip: set ptr=3 (prior grant on channel 2), in_valid=1010. Required: grants are 3 then 1 then 3. Then in_valid=0010: channel 1 is granted every cycle.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=16'hBEEF. Required: out_data, out_src and out_valid stable, in_ready=0000. On the cycle out_ready returns to 1, the next word loads with no gap.
- Out-of-range select: N_IN=3, mode=1, sel=3, in_valid=111. Required: in_ready=000, out_valid=0, no X on any output.

Source files
------------

// File: rtl/arb_mux.sv
// N_IN-to-1 WIDTH-bit mux with round-robin or fixed-select arbitration and a registered output.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 word/cycle while out_ready=1.
// Backpressure: a held output word (out_valid & !out_ready) forces in_ready to zero until it drains.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   mode, sel        - 0 = round-robin, 1 = fixed channel sel
//   in_data/valid    - packed per-channel data (channel i at [i*WIDTH +: WIDTH]) and requests
//   in_ready         - per-channel accept, one-hot or zero
//   out_data/src     - registered winning word and its channel index
//   out_valid/ready  - output handshake
module arb_mux #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  out_ready
);

  logic              load;
  logic              gv;
  logic [SEL_W-1:0]  g;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_nxt;
  logic [2*N_IN-1:0] rot;

  // The output register can take a new word when empty or draining this cycle.
  assign load = !out_valid | out_ready;

  always_comb begin
    // Bit k of rot is the request of channel (ptr + k) mod N_IN.
    rot = {in_valid, in_valid} >> ptr;
    g   = '0;
    gv  = 1'b0;
    if (mode) begin
      // Indices beyond N_IN (non-power-of-2 N_IN) grant nothing.
      if (int'(sel) < N_IN) begin
        g  = sel;
        gv = in_valid[sel];
      end
    end else begin
      // Scan from the far end so the lowest offset from ptr wins last.
      for (int k = N_IN - 1; k >= 0; k--) begin
        if (rot[k]) begin
          gv = 1'b1;
          if (int'(ptr) + k >= N_IN) begin
            g = SEL_W'(int'(ptr) + k - N_IN);
          end else begin
            g = SEL_W'(int'(ptr) + k);
          end
        end
      end
    end
  end

  assign ptr_nxt = (int'(g) == N_IN - 1) ? '0 : g + 1'b1;

  // rst_n gates in_ready so nothing is accepted while reset is held.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = rst_n & load & gv & (g == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (gv) begin
        out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
        out_src   <= g;
        out_valid <= 1'b1;
        if (!mode) begin
          ptr <= ptr_nxt;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4-channel instance for the main sequence and
// a 3-channel instance for the out-of-range select case.
module tb_arb_mux;

  logic        clk;
  logic        rst_n;

  // 4-channel instance
  logic        mode4;
  logic [1:0]  sel4;
  logic [15:0] d4 [4];
  logic [63:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic [15:0] out_data4;
  logic        out_valid4;
  logic [1:0]  out_src4;
  logic        out_ready4;

  // 3-channel instance
  logic        mode3;
  logic [1:0]  sel3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [15:0] out_data3;
  logic        out_valid3;
  logic [1:0]  out_src3;
  logic        out_ready3;

  int tests = 0;
  int fails = 0;

  assign in_data4 = {d4[3], d4[2], d4[1], d4[0]};
  assign in_data3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};

  arb_mux #(.WIDTH(16), .N_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_src(out_src4),
    .out_ready(out_ready4)
  );

  arb_mux #(.WIDTH(16), .N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_src(out_src3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out4(input string tag, input logic [15:0] d, input logic [1:0] s, input logic v);
    chk({tag, "_data"},  {16'h0, out_data4},  {16'h0, d});
    chk({tag, "_src"},   {30'h0, out_src4},   {30'h0, s});
    chk({tag, "_valid"}, {31'h0, out_valid4}, {31'h0, v});
  endtask

  initial begin
    rst_n      = 1'b0;
    mode4      = 1'b0;
    sel4       = 2'd0;
    d4[0]      = 16'h1111;
    d4[1]      = 16'h2222;
    d4[2]      = 16'h3333;
    d4[3]      = 16'h4444;
    in_valid4  = 4'b1111;
    out_ready4 = 1'b1;
    mode3      = 1'b1;
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    out_ready3 = 1'b1;

    // Reset state, with requests already present
    #12;
    chk_out4("rst0", 16'h0000, 2'd0, 1'b0);
    chk("rst0_in_ready", {28'h0, in_ready4}, 32'h0);

    // Round-robin: all channels requesting, ptr starts at 0
    tick();
    rst_n = 1'b1;
    #1;
    chk("rr_first_ready", {28'h0, in_ready4}, 32'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out4($sformatf("rr%0d", i), 16'h1111 * 16'(i % 4 + 1), 2'(i % 4), 1'b1);
    end
    tick();
    chk_out4("rr6", 16'h3333, 2'd2, 1'b1); // ptr now 3

    // Pointer wrap and skip
    in_valid4 = 4'b1010;
    #1;
    chk("wrap_ready_a", {28'h0, in_ready4}, 32'b1000);
    tick();
    chk_out4("wrap_a", 16'h4444, 2'd3, 1'b1);
    chk("wrap_ready_b", {28'h0, in_ready4}, 32'b0010);
    tick();
    chk_out4("wrap_b", 16'h2222, 2'd1, 1'b1);
    chk("wrap_ready_c", {28'h0, in_ready4}, 32'b1000);
    tick();
    chk_out4("wrap_c", 16'h4444, 2'd3, 1'b1);
    in_valid4 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("single_ready%0d", i), {28'h0, in_ready4}, 32'b0010);
      tick();
      chk_out4($sformatf("single%0d", i), 16'h2222, 2'd1, 1'b1);
    end

    // Backpressure holding 16'hBEEF
    d4[0]     = 16'hBEEF;
    mode4     = 1'b1;
    sel4      = 2'd0;
    in_valid4 = 4'b0001;
    #1;
    chk("bp_load_ready", {28'h0, in_ready4}, 32'b0001);
    tick();
    chk_out4("bp_load", 16'hBEEF, 2'd0, 1'b1);
    out_ready4 = 1'b0;
    mode4      = 1'b0;
    in_valid4  = 4'b0100;
    #1;
    chk("bp_ready_hold", {28'h0, in_ready4}, 32'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out4($sformatf("bp_hold%0d", i), 16'hBEEF, 2'd0, 1'b1);
      chk($sformatf("bp_hold_ready%0d", i), {28'h0, in_ready4}, 32'b0000);
    end
    out_ready4 = 1'b1;
    #1;
    chk("bp_release_ready", {28'h0, in_ready4}, 32'b0100);
    tick();
    chk_out4("bp_nogap", 16'h3333, 2'd2, 1'b1); // ptr now 3

    // Fixed select on channel 2; ptr must stay at 3
    d4[0]     = 16'h1111;
    mode4     = 1'b1;
    sel4      = 2'd2;
    in_valid4 = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fix_ready%0d", i), {28'h0, in_ready4}, 32'b0100);
      tick();
      chk_out4($sformatf("fix%0d", i), 16'h3333, 2'd2, 1'b1);
    end
    in_valid4 = 4'b1011;
    #1;
    chk("fix_drop_ready", {28'h0, in_ready4}, 32'b0000);
    tick();
    chk_out4("fix_drop", 16'h3333, 2'd2, 1'b0);

    // Back to round-robin: resumes from ptr=3
    mode4     = 1'b0;
    in_valid4 = 4'b1111;
    #1;
    chk("resume_ready", {28'h0, in_ready4}, 32'b1000);
    tick();
    chk_out4("resume", 16'h4444, 2'd3, 1'b1);

    // Asynchronous reset while holding a valid word
    #1;
    rst_n = 1'b0;
    #1;
    chk_out4("rst1", 16'h0000, 2'd0, 1'b0);
    chk("rst1_in_ready", {28'h0, in_ready4}, 32'h0);
    tick();
    chk_out4("rst1_held", 16'h0000, 2'd0, 1'b0);
    in_valid4 = 4'b0110;
    rst_n     = 1'b1;
    #1;
    chk("post_rst_ready", {28'h0, in_ready4}, 32'b0010);
    tick();
    chk_out4("post_rst", 16'h2222, 2'd1, 1'b1);

    // 3-channel instance: sel=3 is out of range
    chk("n3_oor_ready", {29'h0, in_ready3}, 32'b000);
    chk("n3_oor_valid", {31'h0, out_valid3}, 32'h0);
    chk("n3_oor_nox", {31'h0, $isunknown({in_ready3, out_data3, out_valid3, out_src3})}, 32'h0);
    sel3 = 2'd1;
    #1;
    chk("n3_sel1_ready", {29'h0, in_ready3}, 32'b010);
    tick();
    chk("n3_sel1_data", {16'h0, out_data3}, 32'hBBBB);
    chk("n3_sel1_src", {30'h0, out_src3}, 32'd1);
    chk("n3_sel1_valid", {31'h0, out_valid3}, 32'h1);
    sel3 = 2'd3;
    #1;
    chk("n3_oor2_ready", {29'h0, in_ready3}, 32'b000);
    tick();
    chk("n3_oor2_valid", {31'h0, out_valid3}, 32'h0);
    chk("n3_oor2_data", {16'h0, out_data3}, 32'hBBBB);
    chk("n3_oor2_nox", {31'h0, $isunknown({in_ready3, out_data3, out_valid3, out_src3})}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
